// File: rtl/pal_pattern_sequencer.sv
// Frame-synchronous pattern scheduler for the PAL test-pattern generator.
// Steps through a {pattern, dwell} table and changes pat_sel only at frame boundaries.
module pal_pattern_sequencer #(
   parameter int ENTRIES = 8,
   parameter int PAT_W   = 3,
   parameter int DWELL_W = 8,
   localparam int IDX_W  = $clog2(ENTRIES)
) (
   input  logic               pclk,
   input  logic               rst_n,
   input  logic               frame_end,
   input  logic               cfg_we,
   input  logic [IDX_W-1:0]   cfg_addr,
   input  logic [PAT_W-1:0]   cfg_pat,
   input  logic [DWELL_W-1:0] cfg_dwell,
   input  logic [IDX_W:0]     cfg_len,
   input  logic               loop,
   input  logic               run,
   input  logic               stop,
   output logic [PAT_W-1:0]   pat_sel,
   output logic [IDX_W-1:0]   pat_idx,
   output logic               busy,
   output logic               seq_done
);

   typedef enum logic [1:0] {IDLE, ARM, RUN, DRAIN} state_t;

   state_t             state, state_nx;
   logic [PAT_W-1:0]   pat_mem   [ENTRIES];
   logic [DWELL_W-1:0] dwell_mem [ENTRIES];
   logic [DWELL_W-1:0] cnt, cnt_nx;
   logic [IDX_W:0]     len_sh, len_nx, len_eff;
   logic               loop_sh, loop_nx;
   logic [PAT_W-1:0]   pat_sel_nx;
   logic [IDX_W-1:0]   idx_nx, next_idx;
   logic               done_nx, at_last;

   // Dwell of 0 is treated as 1 frame, so the counter starts at max(d,1)-1.
   function automatic logic [DWELL_W-1:0] first_cnt(input logic [DWELL_W-1:0] d);
      return (d == '0) ? '0 : d - 1'b1;
   endfunction

   always_ff @(posedge pclk) begin
      if (cfg_we) begin
         pat_mem[cfg_addr]   <= cfg_pat;
         dwell_mem[cfg_addr] <= cfg_dwell;
      end
   end

   always_comb begin
      len_eff = cfg_len;
      if (cfg_len == '0)
         len_eff = (IDX_W+1)'(1);
      else if (cfg_len > (IDX_W+1)'(ENTRIES))
         len_eff = (IDX_W+1)'(ENTRIES);
   end

   assign next_idx = pat_idx + 1'b1;
   assign at_last  = ({1'b0, pat_idx} == (len_sh - 1'b1));
   assign busy     = (state != IDLE);

   always_comb begin
      state_nx   = state;
      pat_sel_nx = pat_sel;
      idx_nx     = pat_idx;
      cnt_nx     = cnt;
      len_nx     = len_sh;
      loop_nx    = loop_sh;
      done_nx    = 1'b0;
      case (state)
         IDLE: begin
            pat_sel_nx = '0;
            if (run && !stop) begin
               state_nx = ARM;
               len_nx   = len_eff;
               loop_nx  = loop;
            end
         end
         ARM: begin
            if (stop) begin
               state_nx = DRAIN;
            end else if (frame_end) begin
               state_nx   = RUN;
               pat_sel_nx = pat_mem[0];
               idx_nx     = '0;
               cnt_nx     = first_cnt(dwell_mem[0]);
            end
         end
         RUN: begin
            if (frame_end) begin
               if (cnt != '0) begin
                  cnt_nx = cnt - 1'b1;
               end else if (!at_last) begin
                  idx_nx     = next_idx;
                  pat_sel_nx = pat_mem[next_idx];
                  cnt_nx     = first_cnt(dwell_mem[next_idx]);
               end else if (loop_sh) begin
                  len_nx     = len_eff;
                  idx_nx     = '0;
                  pat_sel_nx = pat_mem[0];
                  cnt_nx     = first_cnt(dwell_mem[0]);
               end else begin
                  state_nx   = IDLE;
                  pat_sel_nx = '0;
                  idx_nx     = '0;
                  done_nx    = 1'b1;
               end
            end
            // A finishing one-shot takes priority; otherwise stop drains after the advance.
            if (stop && state_nx == RUN)
               state_nx = DRAIN;
         end
         DRAIN: begin
            if (frame_end) begin
               state_nx   = IDLE;
               pat_sel_nx = '0;
               idx_nx     = '0;
               done_nx    = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge pclk) begin
      if (!rst_n) begin
         state    <= IDLE;
         pat_sel  <= '0;
         pat_idx  <= '0;
         cnt      <= '0;
         len_sh   <= (IDX_W+1)'(1);
         loop_sh  <= 1'b0;
         seq_done <= 1'b0;
      end else begin
         state    <= state_nx;
         pat_sel  <= pat_sel_nx;
         pat_idx  <= idx_nx;
         cnt      <= cnt_nx;
         len_sh   <= len_nx;
         loop_sh  <= loop_nx;
         seq_done <= done_nx;
      end
   end

endmodule

// File: tb/tb_pal_pattern_sequencer.sv
// Directed bench for pal_pattern_sequencer with a frame-queue reference model
// compared on every cycle, plus literal expectations from the test plan.
module tb_pal_pattern_sequencer;

   logic       pclk = 1'b0;
   logic       rst_n = 1'b0;
   logic       frame_end = 1'b0;
   logic       cfg_we = 1'b0;
   logic [2:0] cfg_addr = '0;
   logic [2:0] cfg_pat = '0;
   logic [7:0] cfg_dwell = '0;
   logic [3:0] cfg_len = 4'd1;
   logic       loop = 1'b0;
   logic       run = 1'b0;
   logic       stop = 1'b0;
   logic [2:0] pat_sel;
   logic [2:0] pat_idx;
   logic       busy;
   logic       seq_done;

   int checks = 0;
   int failures = 0;

   pal_pattern_sequencer dut (
      .pclk(pclk), .rst_n(rst_n), .frame_end(frame_end),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_pat(cfg_pat),
      .cfg_dwell(cfg_dwell), .cfg_len(cfg_len), .loop(loop),
      .run(run), .stop(stop), .pat_sel(pat_sel), .pat_idx(pat_idx),
      .busy(busy), .seq_done(seq_done)
   );

   always #5 pclk = ~pclk;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
      end
   endtask

   // Reference model: phases 0 idle, 1 armed, 2 running, 3 draining.
   // A loaded entry expands into a queue of per-frame pattern ids.
   int m_pat   [8];
   int m_dwell [8];
   int m_phase = 0;
   int m_len   = 1;
   bit m_loop  = 1'b0;
   int q[$];
   int exp_sel = 0;
   int exp_idx = 0;
   bit exp_done = 1'b0;
   bit fe_s, rst_s;
   int sel_before;

   initial for (int i = 0; i < 8; i++) begin
      m_pat[i] = 0;
      m_dwell[i] = 0;
   end

   function automatic int clamp_len(input int l);
      if (l < 1) return 1;
      if (l > 8) return 8;
      return l;
   endfunction

   task automatic show_entry(input int i);
      int frames;
      exp_idx = i;
      q.delete();
      frames = (m_dwell[i] == 0) ? 1 : m_dwell[i];
      for (int k = 0; k < frames; k++) q.push_back(m_pat[i]);
      exp_sel = q.pop_front();
   endtask

   task automatic finish_seq();
      m_phase  = 0;
      exp_sel  = 0;
      exp_idx  = 0;
      exp_done = 1'b1;
      q.delete();
   endtask

   always @(posedge pclk) begin
      fe_s = frame_end;
      rst_s = rst_n;
      sel_before = int'(pat_sel);
      exp_done = 1'b0;
      if (!rst_n) begin
         m_phase = 0; m_len = 1; m_loop = 1'b0;
         exp_sel = 0; exp_idx = 0;
         q.delete();
      end else begin
         case (m_phase)
            0: if (run && !stop) begin
                  m_phase = 1;
                  m_len = clamp_len(int'(cfg_len));
                  m_loop = loop;
               end
            1: if (stop) m_phase = 3;
               else if (frame_end) begin
                  m_phase = 2;
                  show_entry(0);
               end
            2: begin
               if (frame_end) begin
                  if (q.size() > 0) exp_sel = q.pop_front();
                  else if (exp_idx + 1 < m_len) show_entry(exp_idx + 1);
                  else if (m_loop) begin
                     m_len = clamp_len(int'(cfg_len));
                     show_entry(0);
                  end else finish_seq();
               end
               if (stop && m_phase == 2) m_phase = 3;
            end
            default: if (frame_end) finish_seq();
         endcase
      end
      if (cfg_we) begin
         m_pat[cfg_addr] = int'(cfg_pat);
         m_dwell[cfg_addr] = int'(cfg_dwell);
      end
      #1;
      checkOutput("model_pat_sel", int'(pat_sel), exp_sel);
      checkOutput("model_pat_idx", int'(pat_idx), exp_idx);
      checkOutput("model_busy", int'(busy), (m_phase != 0) ? 1 : 0);
      checkOutput("model_seq_done", int'(seq_done), int'(exp_done));
      if (int'(pat_sel) != sel_before)
         checkOutput("sel_change_only_after_frame_end", int'(fe_s || !rst_s), 1);
   end

   // Drives one cycle of inputs at the falling edge; pulses return to 0 afterwards.
   task automatic applyStimulus(input bit r, input bit s, input bit fe, input bit we,
                                input int addr, input int pat, input int dw);
      run = r; stop = s; frame_end = fe; cfg_we = we;
      cfg_addr = addr[2:0]; cfg_pat = pat[2:0]; cfg_dwell = dw[7:0];
      @(negedge pclk);
      run = 1'b0; stop = 1'b0; frame_end = 1'b0; cfg_we = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge pclk);
   endtask

   task automatic write_entry(input int a, input int p, input int d);
      applyStimulus(0, 0, 0, 1, a, p, d);
   endtask

   task automatic frame();
      applyStimulus(0, 0, 1, 0, 0, 0, 0);
      idle(3);
   endtask

   task automatic start();
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      idle(2);
   endtask

   int seq3 [10] = '{3, 3, 5, 3, 3, 5, 3, 3, 5, 3};

   initial begin
      // Reset held for two cycles
      rst_n = 1'b0;
      idle(2);
      checkOutput("reset_pat_sel", int'(pat_sel), 0);
      checkOutput("reset_busy", int'(busy), 0);
      checkOutput("reset_seq_done", int'(seq_done), 0);
      rst_n = 1'b1;
      idle(1);

      write_entry(0, 3, 2);
      write_entry(1, 5, 1);
      for (int i = 2; i < 8; i++) write_entry(i, 1, 1);

      // One-shot two-entry sequence
      $display("[TB] one-shot sequence");
      cfg_len = 4'd2; loop = 1'b0;
      start();
      checkOutput("arm_busy", int'(busy), 1);
      checkOutput("arm_pat_sel", int'(pat_sel), 0);
      frame(); checkOutput("oneshot_f1", int'(pat_sel), 3);
      frame(); checkOutput("oneshot_f2", int'(pat_sel), 3);
      frame(); checkOutput("oneshot_f3", int'(pat_sel), 5);
      applyStimulus(0, 0, 1, 0, 0, 0, 0);
      checkOutput("oneshot_done_pulse", int'(seq_done), 1);
      checkOutput("oneshot_done_sel", int'(pat_sel), 0);
      idle(1);
      checkOutput("oneshot_done_single", int'(seq_done), 0);
      checkOutput("oneshot_idle", int'(busy), 0);

      // Looping sequence, then reset mid-run
      $display("[TB] looping sequence");
      loop = 1'b1;
      start();
      for (int f = 0; f < 10; f++) begin
         frame();
         checkOutput($sformatf("loop_f%0d", f + 1), int'(pat_sel), seq3[f]);
      end
      checkOutput("loop_busy", int'(busy), 1);
      rst_n = 1'b0;
      idle(1);
      rst_n = 1'b1;
      checkOutput("midreset_sel", int'(pat_sel), 0);
      checkOutput("midreset_busy", int'(busy), 0);
      checkOutput("midreset_no_done", int'(seq_done), 0);
      idle(2);

      // Dwell 0 and cfg_len clamping
      $display("[TB] dwell zero and length clamp");
      write_entry(0, 3, 0);
      cfg_len = 4'd0; loop = 1'b0;
      start();
      frame(); checkOutput("len0_f1", int'(pat_sel), 3);
      applyStimulus(0, 0, 1, 0, 0, 0, 0);
      checkOutput("len0_done", int'(seq_done), 1);
      idle(2);
      cfg_len = 4'd15;
      start();
      for (int f = 0; f < 8; f++) frame();
      checkOutput("len15_f8_sel", int'(pat_sel), 1);
      checkOutput("len15_f8_busy", int'(busy), 1);
      applyStimulus(0, 0, 1, 0, 0, 0, 0);
      checkOutput("len15_done", int'(seq_done), 1);
      idle(2);

      // Stop mid-dwell, run+stop in idle, run+frame_end in idle
      $display("[TB] stop handling");
      write_entry(0, 3, 4);
      cfg_len = 4'd1;
      start();
      frame();
      applyStimulus(0, 1, 0, 0, 0, 0, 0);
      idle(2);
      checkOutput("drain_hold_sel", int'(pat_sel), 3);
      checkOutput("drain_busy", int'(busy), 1);
      applyStimulus(0, 0, 1, 0, 0, 0, 0);
      checkOutput("drain_done", int'(seq_done), 1);
      checkOutput("drain_sel0", int'(pat_sel), 0);
      idle(2);
      applyStimulus(1, 1, 0, 0, 0, 0, 0);
      idle(1);
      checkOutput("runstop_idle", int'(busy), 0);
      applyStimulus(1, 0, 1, 0, 0, 0, 0);
      idle(1);
      checkOutput("run_fe_arm_busy", int'(busy), 1);
      checkOutput("run_fe_arm_sel", int'(pat_sel), 0);
      applyStimulus(0, 1, 0, 0, 0, 0, 0);
      frame();
      checkOutput("arm_stop_idle", int'(busy), 0);

      // Table rewrite while shown, and same-cycle write to the entry being loaded
      $display("[TB] table rewrite");
      write_entry(0, 3, 1);
      write_entry(1, 5, 1);
      cfg_len = 4'd2; loop = 1'b1;
      start();
      frame();
      write_entry(0, 6, 1);
      idle(1);
      checkOutput("rewrite_current", int'(pat_sel), 3);
      frame(); checkOutput("rewrite_e1", int'(pat_sel), 5);
      frame(); checkOutput("rewrite_new", int'(pat_sel), 6);
      frame(); checkOutput("rewrite_e1b", int'(pat_sel), 5);
      applyStimulus(0, 0, 1, 1, 0, 7, 1);
      idle(2);
      checkOutput("samecycle_old", int'(pat_sel), 6);
      frame(); checkOutput("samecycle_e1", int'(pat_sel), 5);
      frame(); checkOutput("samecycle_new", int'(pat_sel), 7);

      // Stop together with frame_end in RUN still advances
      $display("[TB] stop with frame_end");
      applyStimulus(0, 1, 1, 0, 0, 0, 0);
      idle(2);
      checkOutput("stopfe_advance", int'(pat_sel), 5);
      checkOutput("stopfe_busy", int'(busy), 1);
      applyStimulus(0, 0, 1, 0, 0, 0, 0);
      checkOutput("stopfe_done", int'(seq_done), 1);
      idle(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
